// File: rtl/tape_recorder.sv
// MIC-to-TAP recorder: times mic half-periods in T-states, decodes pilot/sync/data pulses
// and writes each block, prefixed by its 16-bit little-endian length, to the tape region.
module tape_recorder #(
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned T_GLITCH  = 400,
  parameter int unsigned T_SHORT   = 1280,
  parameter int unsigned T_ONE     = 1940,
  parameter int unsigned T_PILOT   = 2800,
  parameter int unsigned T_GAP     = 7000,
  parameter int unsigned MIN_PILOT = 256
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              enable,
  input  logic              mic,
  output logic [ADDR_W-1:0] buff_addr,
  output logic [7:0]        buff_dout,
  output logic              buff_wr,
  input  logic              buff_ack,
  output logic [ADDR_W-1:0] tape_size,
  output logic              active,
  output logic              err,
  output logic              overflow
);

  localparam int unsigned SumW = ADDR_W + 17;
  localparam logic [15:0] TGlitch  = 16'(T_GLITCH);
  localparam logic [15:0] TShort   = 16'(T_SHORT);
  localparam logic [15:0] TOne     = 16'(T_ONE);
  localparam logic [15:0] TPilot   = 16'(T_PILOT);
  localparam logic [15:0] TGapM1   = 16'(T_GAP - 1);
  localparam logic [15:0] PilotMin = 16'(MIN_PILOT);
  localparam logic [SumW-1:0] AddrMax = SumW'((64'd1 << ADDR_W) - 64'd1);

  typedef enum logic [2:0] {
    StIdle, StPilot, StSync, StDataA, StDataB, StLenLo, StLenHi
  } state_e;

  typedef enum logic [1:0] {ClsShort, ClsOne, ClsPilot, ClsInvalid} cls_e;

  state_e state_q, state_d;
  cls_e   hp_cls, cls_a_q, cls_a_d;

  logic              mic_q, mic_prev_q, enable_q;
  logic [15:0]       cnt_q, cnt_d, pcnt_q, pcnt_d, len_q, len_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] block_start_q, block_start_d, tape_size_q, tape_size_d;
  logic              err_q, err_d, overflow_q, overflow_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;

  logic              edge_det, hp_valid, gap_hit, end_block;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [SumW-1:0]   sum_full;
  logic [ADDR_W-1:0] data_addr;
  logic              ovf_hit;
  logic [7:0]        byte_full;

  // Sub-glitch edges leave the counter running so the real half-period keeps accumulating.
  assign edge_det = mic_q ^ mic_prev_q;
  assign hp_valid = edge_det && (cnt_q >= TGlitch);
  assign gap_hit  = ce && !hp_valid && (cnt_q == TGapM1);

  always_comb begin
    cnt_d = cnt_q;
    if (hp_valid) begin
      cnt_d = '0;
    end else if (ce && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    if (cnt_q < TShort)      hp_cls = ClsShort;
    else if (cnt_q < TOne)   hp_cls = ClsOne;
    else if (cnt_q < TPilot) hp_cls = ClsPilot;
    else                     hp_cls = ClsInvalid;
  end

  assign sum_full  = SumW'(block_start_q) + SumW'(len_q) + SumW'(2);
  assign data_addr = sum_full[ADDR_W-1:0];
  assign ovf_hit   = (sum_full + SumW'(1)) > AddrMax;
  assign byte_full = {shift_q, hp_cls == ClsOne};

  always_comb begin
    state_d       = state_q;
    cls_a_d       = cls_a_q;
    pcnt_d        = pcnt_q;
    len_d         = len_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    block_start_d = block_start_q;
    tape_size_d   = tape_size_q;
    err_d         = err_q;
    overflow_d    = overflow_q;
    wr_req        = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    end_block     = 1'b0;

    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (hp_valid && (hp_cls == ClsPilot) && !overflow_q) begin
            state_d = StPilot;
            pcnt_d  = 16'd1;
          end
        end
        StPilot: begin
          if (hp_valid) begin
            unique case (hp_cls)
              ClsPilot: if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
              ClsShort: state_d = (pcnt_q >= PilotMin) ? StSync : StIdle;
              default:  state_d = StIdle;
            endcase
          end
        end
        StSync: begin
          if (hp_valid) begin
            if (hp_cls == ClsShort) begin
              state_d  = StDataA;
              len_d    = '0;
              bitcnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDataA: begin
          if (hp_valid) begin
            if ((hp_cls == ClsShort) || (hp_cls == ClsOne)) begin
              cls_a_d = hp_cls;
              state_d = StDataB;
            end else begin
              end_block = 1'b1;
            end
          end else if (gap_hit) begin
            end_block = 1'b1;
          end
        end
        StDataB: begin
          if (hp_valid) begin
            if (hp_cls != cls_a_q) begin
              err_d     = 1'b1;
              end_block = 1'b1;
            end else begin
              shift_d  = byte_full[6:0];
              bitcnt_d = bitcnt_q + 3'd1;
              state_d  = StDataA;
              if (bitcnt_q == 3'd7) begin
                if (ovf_hit) begin
                  overflow_d = 1'b1;
                  state_d    = StIdle;
                end else begin
                  // Only one write may be outstanding; a collision loses the byte.
                  if (wr_q) begin
                    err_d = 1'b1;
                  end else begin
                    wr_req  = 1'b1;
                    wr_addr = data_addr;
                    wr_data = byte_full;
                  end
                  len_d = len_q + 16'd1;
                end
              end
            end
          end else if (gap_hit) begin
            end_block = 1'b1;
          end
        end
        StLenLo: begin
          if (!wr_q) begin
            wr_req  = 1'b1;
            wr_addr = block_start_q;
            wr_data = len_q[7:0];
            state_d = StLenHi;
          end
        end
        StLenHi: begin
          if (!wr_q) begin
            wr_req        = 1'b1;
            wr_addr       = block_start_q + ADDR_W'(1);
            wr_data       = len_q[15:8];
            block_start_d = data_addr;
            tape_size_d   = data_addr;
            state_d       = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (end_block) begin
        state_d = (len_q == 16'd0) ? StIdle : StLenLo;
      end

      if (!enable_q) begin
        err_d         = 1'b0;
        block_start_d = '0;
        tape_size_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mic_q         <= 1'b0;
      mic_prev_q    <= 1'b0;
      enable_q      <= 1'b0;
      cnt_q         <= '0;
      state_q       <= StIdle;
      cls_a_q       <= ClsShort;
      pcnt_q        <= '0;
      len_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      block_start_q <= '0;
      tape_size_q   <= '0;
      err_q         <= 1'b0;
      overflow_q    <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
    end else begin
      mic_q         <= mic;
      mic_prev_q    <= mic_q;
      enable_q      <= enable;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      cls_a_q       <= cls_a_d;
      pcnt_q        <= pcnt_d;
      len_q         <= len_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      block_start_q <= block_start_d;
      tape_size_q   <= tape_size_d;
      err_q         <= err_d;
      overflow_q    <= overflow_d;
      if (wr_req) begin
        wr_q   <= 1'b1;
        addr_q <= wr_addr;
        dout_q <= wr_data;
      end else if (wr_q && buff_ack) begin
        wr_q <= 1'b0;
      end
    end
  end

  assign buff_addr = addr_q;
  assign buff_dout = dout_q;
  assign buff_wr   = wr_q;
  assign tape_size = tape_size_q;
  assign active    = (state_q != StIdle);
  assign err       = err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tape_recorder.sv
// Bench for tape_recorder with timing thresholds scaled down; a second 6-bit-address
// instance covers tape-region overflow.
module tb_tape_recorder;

  localparam int unsigned AW  = 22;
  localparam int unsigned AWS = 6;
  localparam int HP_PILOT = 24, HP_ZERO = 9, HP_ONE = 16, HP_SIL = 100;

  logic clk_sys = 1'b0, reset = 1'b1, reset_s = 1'b1, ce = 1'b0, enable = 1'b0, mic = 1'b0;
  logic [AW-1:0]  buff_addr, tape_size;
  logic [7:0]     buff_dout;
  logic           buff_wr, buff_ack = 1'b0, active, err, overflow;
  logic [AWS-1:0] buff_addr_s, tape_size_s;
  logic [7:0]     buff_dout_s;
  logic           buff_wr_s, ack_s = 1'b0, active_s, err_s, overflow_s;

  tape_recorder #(
    .ADDR_W(AW), .T_GLITCH(4), .T_SHORT(13), .T_ONE(20), .T_PILOT(28), .T_GAP(70),
    .MIN_PILOT(8)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .enable(enable), .mic(mic),
    .buff_addr(buff_addr), .buff_dout(buff_dout), .buff_wr(buff_wr), .buff_ack(buff_ack),
    .tape_size(tape_size), .active(active), .err(err), .overflow(overflow)
  );

  tape_recorder #(
    .ADDR_W(AWS), .T_GLITCH(4), .T_SHORT(13), .T_ONE(20), .T_PILOT(28), .T_GAP(70),
    .MIN_PILOT(8)
  ) dut_s (
    .clk_sys(clk_sys), .reset(reset_s), .ce(ce), .enable(enable), .mic(mic),
    .buff_addr(buff_addr_s), .buff_dout(buff_dout_s), .buff_wr(buff_wr_s), .buff_ack(ack_s),
    .tape_size(tape_size_s), .active(active_s), .err(err_s), .overflow(overflow_s)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) ack_s <= buff_wr_s && !ack_s;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    bit rearm;
    int ack;
    int pilots;
    int nbytes;
    int kind;
    int bad_at;
    int exp_len;
    int exp_size;
    bit exp_err;
  } vec_t;

  wr_t  log_q[$];
  vec_t tbl[6];
  int   n_cmp = 0, n_bad = 0, ack_dly = 2, wr_cycles = 0;
  logic pw = 1'b0, pa = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [7:0]    pdat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int i);
    case (kind)
      0:       byte_of = (i == 0) ? 8'h00 : (i == 1) ? 8'h03 : 8'(i * 29 + 7);
      1:       byte_of = (i == 0) ? 8'hFF : 8'hA5;
      default: byte_of = 8'(i * 13 + 90);
    endcase
  endfunction

  // T-state enable every other clock
  initial forever begin
    @(posedge clk_sys); #1;
    ce = ~ce;
  end

  initial forever begin
    @(posedge clk_sys); #1;
    buff_ack = 1'b0;
    if (buff_wr) begin
      repeat (ack_dly - 1) begin @(posedge clk_sys); #1; end
      buff_ack = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk_sys);
    if (buff_wr) wr_cycles++;
    if (buff_wr && pw && !pa) begin
      check("addr_stable", 32'(buff_addr), 32'(paddr));
      check("data_stable", 32'(buff_dout), 32'(pdat));
    end
    if (buff_wr && buff_ack) log_q.push_back('{a: buff_addr, d: buff_dout});
    pw = buff_wr; pa = buff_ack; paddr = buff_addr; pdat = buff_dout;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic half(input int n);
    mic = ~mic;
    repeat (2 * n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_block(input int pilots, input int nbytes, input int kind, input int bad_at);
    logic [7:0] b;
    int w;
    for (int p = 0; p < pilots; p++) half(HP_PILOT);
    half(7);
    half(8);
    for (int i = 0; i < nbytes; i++) begin
      b = byte_of(kind, i);
      for (int k = 0; k < 8; k++) begin
        if (i * 8 + k == bad_at) begin
          half(HP_ZERO);
          half(HP_ONE);
          half(HP_SIL);
          return;
        end
        w = b[7-k] ? HP_ONE : HP_ZERO;
        half(w);
        half(w);
      end
    end
    half(HP_SIL);
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((active || buff_wr) && t < 3000) begin
      @(posedge clk_sys); #1;
      t++;
    end
    check("quiet_timeout", 32'(active || buff_wr), 32'd0);
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int exp_bs, nexp;
    logic [AW-1:0] ea;
    logic [7:0] ed;

    tbl[0] = '{0, 2, 40, 19, 0, -1, 19, 21, 0};
    tbl[1] = '{0, 2, 20, 2, 1, -1, 2, 25, 0};
    tbl[2] = '{0, 2, 7, 3, 2, -1, 0, 25, 0};
    tbl[3] = '{0, 2, 8, 3, 2, -1, 3, 30, 0};
    tbl[4] = '{0, 2, 20, 3, 2, 20, 2, 34, 1};
    tbl[5] = '{1, 50, 20, 4, 2, -1, 4, 6, 0};

    repeat (4) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(posedge clk_sys); #1;
    check("rst_addr", 32'(buff_addr), 0);
    check("rst_dout", 32'(buff_dout), 0);
    check("rst_wr", 32'(buff_wr), 0);
    check("rst_size", 32'(tape_size), 0);
    check("rst_active", 32'(active), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(overflow), 0);

    enable = 1'b1;
    repeat (1000) @(posedge clk_sys);
    #1;
    check("static_wr_cycles", 32'(wr_cycles), 0);
    check("static_active", 32'(active), 0);
    check("static_size", 32'(tape_size), 0);
    check("static_err", 32'(err), 0);

    exp_bs = 0;
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].rearm) begin
        enable = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1 enable = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        exp_bs = 0;
      end
      ack_dly = tbl[v].ack;
      log_q.delete();
      send_block(tbl[v].pilots, tbl[v].nbytes, tbl[v].kind, tbl[v].bad_at);
      wait_quiet();
      check($sformatf("v%0d_size", v), 32'(tape_size), 32'(tbl[v].exp_size));
      check($sformatf("v%0d_err", v), 32'(err), 32'(tbl[v].exp_err));
      check($sformatf("v%0d_active", v), 32'(active), 0);
      nexp = (tbl[v].exp_len > 0) ? tbl[v].exp_len + 2 : 0;
      check($sformatf("v%0d_nwrites", v), 32'(log_q.size()), 32'(nexp));
      for (int i = 0; i < nexp; i++) begin
        if (i < tbl[v].exp_len) begin
          ea = AW'(exp_bs + 2 + i);
          ed = byte_of(tbl[v].kind, i);
        end else if (i == tbl[v].exp_len) begin
          ea = AW'(exp_bs);
          ed = 8'(tbl[v].exp_len);
        end else begin
          ea = AW'(exp_bs + 1);
          ed = 8'(tbl[v].exp_len >> 8);
        end
        if (i < log_q.size()) begin
          check($sformatf("v%0d_addr%0d", v, i), 32'(log_q[i].a), 32'(ea));
          check($sformatf("v%0d_data%0d", v, i), 32'(log_q[i].d), 32'(ed));
        end
      end
      if (tbl[v].exp_len > 0) exp_bs += tbl[v].exp_len + 2;
    end

    // Block ends exactly when the counter reaches the gap threshold; one partial bit only.
    ack_dly = 2;
    log_q.delete();
    for (int p = 0; p < 20; p++) half(HP_PILOT);
    half(7);
    half(8);
    half(HP_ZERO);
    half(HP_ZERO);
    mic = ~mic;
    repeat (130) @(posedge clk_sys);
    #1;
    check("gap_active_before", 32'(active), 1);
    repeat (20) @(posedge clk_sys);
    #1;
    check("gap_active_after", 32'(active), 0);
    check("gap_nwrites", 32'(log_q.size()), 0);
    repeat (100) @(posedge clk_sys);
    #1;

    reset_s = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    send_block(20, 70, 2, -1);
    wait_quiet();
    check("ovf_flag", 32'(overflow_s), 1);
    check("ovf_size", 32'(tape_size_s), 0);
    check("ovf_active", 32'(active_s), 0);
    check("big_no_ovf", 32'(overflow), 0);
    check("big_size", 32'(tape_size), 78);
    send_block(20, 2, 1, -1);
    wait_quiet();
    check("ovf_hold_size", 32'(tape_size_s), 0);
    check("ovf_hold_flag", 32'(overflow_s), 1);
    check("after_ovf_size", 32'(tape_size), 82);

    ack_dly = 100;
    log_q.delete();
    fork
      send_block(20, 2, 2, -1);
      begin
        int t = 0;
        while (!buff_wr && t < 5000) begin
          @(negedge clk_sys);
          t++;
        end
        check("wr_before_reset", 32'(buff_wr), 1);
        @(posedge clk_sys); #1 reset = 1'b1;
        @(posedge clk_sys); #1 reset = 1'b0;
        check("reset_drops_wr", 32'(buff_wr), 0);
        check("reset_active", 32'(active), 0);
        check("reset_size", 32'(tape_size), 0);
      end
    join
    repeat (200) @(posedge clk_sys);
    #1;
    check("reset_nwrites", 32'(log_q.size()), 0);
    check("reset_wr_idle", 32'(buff_wr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
